// File: rtl/bcd_adjust_seq.sv
// Multi-cycle decimal adjust for a packed-BCD word after binary ADD/SUB.
// One digit per clock, LSD first; Z80 DAA-compatible flags for DIGITS=2.
module bcd_adjust_seq #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  notReset,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a_in,
    input  logic [DIGITS-1:0]     dc_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   result,
    output logic                  flag_s,
    output logic                  flag_z,
    output logic                  flag_h,
    output logic                  flag_pv,
    output logic                  flag_c,
    output logic                  flag_n
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg;
    logic [W-1:0]     a_reg;
    logic [DIGITS-1:0] dc_reg;
    logic             sub_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             g_reg;
    logic             k_reg;
    logic [W-1:0]     work_reg;
    logic [W-1:0]     result_reg;
    logic             flag_s_reg, flag_z_reg, flag_h_reg, flag_pv_reg, flag_c_reg, flag_n_reg;

    logic [3:0]       digit_cur;
    logic             dc_cur;
    logic             g_next;
    logic             corr;
    logic [4:0]       sum5;
    logic [4:0]       diff5;
    logic [3:0]       digit_out;
    logic             k_next;
    logic             last_digit;
    logic [W-1:0]     work_next;
    logic [3:0]       digit0;

    always_comb begin
        digit_cur = 4'd0;
        dc_cur    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                digit_cur = a_reg[4*i +: 4];
                dc_cur    = dc_reg[i];
            end
        end
    end

    // The g chain looks only at the original digits, never at corrected ones.
    assign g_next     = (digit_cur > 4'd9) | ((digit_cur == 4'd9) & g_reg);
    assign corr       = dc_cur | g_next;
    assign sum5       = {1'b0, digit_cur} + (corr ? 5'd6 : 5'd0) + {4'd0, k_reg};
    assign diff5      = {1'b0, digit_cur} - (corr ? 5'd6 : 5'd0) - {4'd0, k_reg};
    assign digit_out  = sub_reg ? diff5[3:0] : sum5[3:0];
    assign k_next     = sub_reg ? diff5[4] : sum5[4];
    assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));
    assign digit0     = a_reg[3:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_work
            assign work_next[4*gi +: 4] = (idx_reg == IDX_W'(gi)) ? digit_out : work_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!notReset) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            dc_reg      <= '0;
            sub_reg     <= 1'b0;
            idx_reg     <= '0;
            g_reg       <= 1'b0;
            k_reg       <= 1'b0;
            work_reg    <= '0;
            result_reg  <= '0;
            flag_s_reg  <= 1'b0;
            flag_z_reg  <= 1'b0;
            flag_h_reg  <= 1'b0;
            flag_pv_reg <= 1'b0;
            flag_c_reg  <= 1'b0;
            flag_n_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        dc_reg    <= dc_in;
                        sub_reg   <= sub;
                        idx_reg   <= '0;
                        g_reg     <= 1'b0;
                        k_reg     <= 1'b0;
                        work_reg  <= '0;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    work_reg <= work_next;
                    g_reg    <= g_next;
                    k_reg    <= k_next;
                    idx_reg  <= idx_reg + 1'b1;
                    // Visible outputs only change as the last digit completes.
                    if (last_digit) begin
                        state_reg   <= DONE;
                        result_reg  <= work_next;
                        flag_s_reg  <= work_next[W-1];
                        flag_z_reg  <= (work_next == '0);
                        flag_pv_reg <= ~^work_next;
                        flag_c_reg  <= corr;
                        flag_h_reg  <= sub_reg ? (dc_reg[0] & (digit0 < 4'd6)) : (digit0 > 4'd9);
                        flag_n_reg  <= sub_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign result  = result_reg;
    assign flag_s  = flag_s_reg;
    assign flag_z  = flag_z_reg;
    assign flag_h  = flag_h_reg;
    assign flag_pv = flag_pv_reg;
    assign flag_c  = flag_c_reg;
    assign flag_n  = flag_n_reg;

endmodule

// File: tb/tb_bcd_adjust_seq.sv
// Randomized bench for bcd_adjust_seq at DIGITS=1, 2 and 4 against a
// whole-word arithmetic model of the decimal adjust.
module tb_bcd_adjust_seq;

    logic clk = 1'b0;
    logic notReset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int sel      = 2;

    logic        start1 = 0, sub1 = 0, busy1, done1, fs1, fz1, fh1, fp1, fc1, fn1;
    logic [3:0]  a1 = '0, res1;
    logic [0:0]  dc1 = '0;
    logic        start2 = 0, sub2 = 0, busy2, done2, fs2, fz2, fh2, fp2, fc2, fn2;
    logic [7:0]  a2 = '0, res2;
    logic [1:0]  dc2 = '0;
    logic        start4 = 0, sub4 = 0, busy4, done4, fs4, fz4, fh4, fp4, fc4, fn4;
    logic [15:0] a4 = '0, res4;
    logic [3:0]  dc4 = '0;

    bcd_adjust_seq #(.DIGITS(1)) dut1 (
        .clk(clk), .notReset(notReset), .start(start1), .sub(sub1), .a_in(a1), .dc_in(dc1),
        .busy(busy1), .done(done1), .result(res1), .flag_s(fs1), .flag_z(fz1),
        .flag_h(fh1), .flag_pv(fp1), .flag_c(fc1), .flag_n(fn1));
    bcd_adjust_seq #(.DIGITS(2)) dut2 (
        .clk(clk), .notReset(notReset), .start(start2), .sub(sub2), .a_in(a2), .dc_in(dc2),
        .busy(busy2), .done(done2), .result(res2), .flag_s(fs2), .flag_z(fz2),
        .flag_h(fh2), .flag_pv(fp2), .flag_c(fc2), .flag_n(fn2));
    bcd_adjust_seq #(.DIGITS(4)) dut4 (
        .clk(clk), .notReset(notReset), .start(start4), .sub(sub4), .a_in(a4), .dc_in(dc4),
        .busy(busy4), .done(done4), .result(res4), .flag_s(fs4), .flag_z(fz4),
        .flag_h(fh4), .flag_pv(fp4), .flag_c(fc4), .flag_n(fn4));

    // Observed signals of the currently selected instance; flags packed {s,z,h,pv,c,n}.
    logic        obs_busy, obs_done;
    logic [15:0] obs_res;
    logic [5:0]  obs_fl;
    always_comb begin
        obs_busy = busy2;
        obs_done = done2;
        obs_res  = {8'd0, res2};
        obs_fl   = {fs2, fz2, fh2, fp2, fc2, fn2};
        case (sel)
            1: begin
                obs_busy = busy1; obs_done = done1; obs_res = {12'd0, res1};
                obs_fl = {fs1, fz1, fh1, fp1, fc1, fn1};
            end
            4: begin
                obs_busy = busy4; obs_done = done4; obs_res = res4;
                obs_fl = {fs4, fz4, fh4, fp4, fc4, fn4};
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Whole-word model: result = a +/- sum(corr_i * 6 * 16^i) mod 2^(4*nd).
    function automatic void model(input int nd, input logic s, input logic [15:0] a,
                                  input logic [3:0] dc, output logic [15:0] res,
                                  output logic [5:0] fl);
        int unsigned adj = 0;
        int unsigned mask = (32'd1 << (4 * nd)) - 1;
        int unsigned r;
        int unsigned d;
        int unsigned d0 = a & 16'hF;
        logic gp = 1'b0;
        logic g;
        logic cor = 1'b0;
        logic sf, zf, hf, pf;
        for (int i = 0; i < nd; i++) begin
            d   = (a >> (4 * i)) & 16'hF;
            g   = (d > 9) || (d == 9 && gp);
            cor = dc[i] || g;
            if (cor) adj += 6 << (4 * i);
            gp  = g;
        end
        r   = s ? ((32'(a) - adj) & mask) : ((32'(a) + adj) & mask);
        res = r[15:0];
        sf  = r[4*nd-1];
        zf  = (r == 0);
        pf  = ~^res;
        hf  = s ? (dc[0] && d0 < 6) : (d0 > 9);
        fl  = {sf, zf, hf, pf, cor, s};
    endfunction

    task automatic drive(input int nd, input logic st, input logic s,
                         input logic [15:0] a, input logic [3:0] dc);
        case (nd)
            1: begin start1 = st; sub1 = s; a1 = a[3:0]; dc1 = dc[0:0]; end
            4: begin start4 = st; sub4 = s; a4 = a; dc4 = dc; end
            default: begin start2 = st; sub2 = s; a2 = a[7:0]; dc2 = dc[1:0]; end
        endcase
    endtask

    task automatic run_op(input int nd, input logic s, input logic [15:0] a, input logic [3:0] dc);
        logic [15:0] er;
        logic [5:0]  ef;
        model(nd, s, a, dc, er, ef);
        sel = nd;
        @(negedge clk);
        drive(nd, 1'b1, s, a, dc);
        @(negedge clk);
        drive(nd, 1'b0, s, a, dc);
        for (int c = 0; c < nd; c++) begin
            check("busy_run", obs_busy, 1);
            check("done_early", obs_done, 0);
            @(negedge clk);
        end
        check("done", obs_done, 1);
        check("busy_done", obs_busy, 0);
        check("result", obs_res, er);
        check("flags", obs_fl, ef);
        $display("op nd=%0d sub=%0b a=%h dc=%b -> res=%h flags=%b (exp %h %b)",
                 nd, s, a, dc, obs_res, obs_fl, er, ef);
        @(negedge clk);
        check("done_pulse", obs_done, 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [3:0]  rdc;
        int          nd;

        repeat (3) @(negedge clk);
        for (int n = 1; n <= 4; n *= 2) begin
            sel = n;
            #1;
            check("rst_busy", obs_busy, 0);
            check("rst_done", obs_done, 0);
            check("rst_res", obs_res, 0);
            check("rst_flags", obs_fl, 0);
        end
        notReset = 1'b1;

        run_op(2, 0, 16'h009A, 4'b00);
        check("tp_9a_res", obs_res, 16'h0000);
        check("tp_9a_flags", obs_fl, 6'b011110);
        run_op(2, 0, 16'h0025, 4'b01);
        check("tp_25_res", obs_res, 16'h002B);
        run_op(2, 1, 16'h000D, 4'b01);
        check("tp_0d_res", obs_res, 16'h0007);
        check("tp_0d_flags", obs_fl, 6'b000001);
        run_op(4, 0, 16'h999A, 4'b0000);
        check("tp_999a_res", obs_res, 16'h0000);
        check("tp_999a_flags", obs_fl, 6'b011110);
        run_op(1, 0, 16'h000A, 4'b0);
        check("d1_wrap_c", obs_fl[1], 1);
        run_op(1, 1, 16'h0003, 4'b1);

        // start during RUN is ignored; start in DONE runs back-to-back
        sel = 2;
        @(negedge clk); drive(2, 1, 0, 16'h0012, 2'b00);
        @(negedge clk); drive(2, 1, 0, 16'h009A, 2'b00);
        check("ign_busy0", obs_busy, 1);
        @(negedge clk); drive(2, 0, 0, 16'h009A, 2'b00);
        check("ign_busy1", obs_busy, 1);
        @(negedge clk);
        check("ign_done", obs_done, 1);
        check("ign_res", obs_res, 16'h0012);
        check("ign_c", obs_fl[1], 0);
        $display("op ignore-during-run -> res=%h flags=%b", obs_res, obs_fl);
        drive(2, 1, 0, 16'h009A, 2'b00);
        @(negedge clk); drive(2, 0, 0, 16'h009A, 2'b00);
        check("b2b_busy0", obs_busy, 1);
        check("b2b_done0", obs_done, 0);
        @(negedge clk);
        check("b2b_busy1", obs_busy, 1);
        @(negedge clk);
        check("b2b_done", obs_done, 1);
        check("b2b_res", obs_res, 16'h0000);
        check("b2b_c", obs_fl[1], 1);
        $display("op back-to-back -> res=%h flags=%b", obs_res, obs_fl);
        @(negedge clk);
        check("b2b_idle", obs_done, 0);

        // reset mid-RUN aborts without a done pulse
        run_op(2, 0, 16'h0025, 2'b01);
        @(negedge clk); drive(2, 1, 0, 16'h009A, 2'b00);
        @(negedge clk); drive(2, 0, 0, 16'h009A, 2'b00);
        check("mid_busy", obs_busy, 1);
        notReset = 1'b0;
        @(negedge clk);
        notReset = 1'b1;
        check("abort_busy", obs_busy, 0);
        check("abort_done", obs_done, 0);
        check("abort_res", obs_res, 0);
        check("abort_flags", obs_fl, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_nodone", obs_done, 0);
        end
        $display("op reset-mid-run -> res=%h flags=%b", obs_res, obs_fl);
        run_op(2, 0, 16'h009A, 2'b00);

        // reset wins over a simultaneous start
        @(negedge clk); drive(2, 1, 0, 16'h0055, 2'b00); notReset = 1'b0;
        @(negedge clk); drive(2, 0, 0, 16'h0055, 2'b00); notReset = 1'b1;
        check("rst_vs_start", obs_busy, 0);
        @(negedge clk);
        check("rst_vs_start2", obs_busy, 0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(2, 0))
                0: nd = 1;
                1: nd = 2;
                default: nd = 4;
            endcase
            ra  = 16'($urandom);
            rdc = 4'($urandom);
            if (nd == 1) begin ra &= 16'h000F; rdc &= 4'h1; end
            if (nd == 2) begin ra &= 16'h00FF; rdc &= 4'h3; end
            run_op(nd, 1'($urandom), ra, rdc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
